// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage forwarding selects plus load-use/MDU stall control for a 5-stage pipeline.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
// WB-stage producers are covered by register-file write-through, so only EX and MEM records are kept.
module fwd_hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter int MDU_LAT = 32,
   parameter int STAT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_mdu_start,
   input  logic              id_use_hilo,
   input  logic              flush,
   output logic              stall,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
`ifdef FWD_STATS_EN
   output logic [STAT_W-1:0] stat_stall_cnt,
   output logic [STAT_W-1:0] stat_fwd_alu_cnt,
   output logic [STAT_W-1:0] stat_fwd_mem_cnt,
`endif
   output logic              mdu_busy
);
   localparam int CW = $clog2(MDU_LAT + 1);
   logic              ex_valid_q, ex_rw_q, ex_mr_q;
   logic [REG_AW-1:0] ex_dst_q;
   logic              mem_valid_q, mem_rw_q;
   logic [REG_AW-1:0] mem_dst_q;
   logic [1:0]        sel_a_q, sel_b_q, sel_a_d, sel_b_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q;
   logic              ex_a, ex_b, mem_a, mem_b, load_use, mdu_stall, advance, mdu_go;
   // Producer matches against the shadow EX/MEM records; register 0 is never forwarded
   always_comb begin
      ex_a      = id_use_rs && id_rs != '0 && ex_valid_q && ex_rw_q && ex_dst_q == id_rs;
      ex_b      = id_use_rt && id_rt != '0 && ex_valid_q && ex_rw_q && ex_dst_q == id_rt;
      mem_a     = id_use_rs && id_rs != '0 && mem_valid_q && mem_rw_q && mem_dst_q == id_rs;
      mem_b     = id_use_rt && id_rt != '0 && mem_valid_q && mem_rw_q && mem_dst_q == id_rt;
      load_use  = ex_mr_q && (ex_a || ex_b);
      mdu_stall = (id_use_hilo || id_mdu_start) && busy_q;
      stall     = id_valid && (load_use || mdu_stall);
      advance   = id_valid && !stall && !flush;
      mdu_go    = advance && id_mdu_start;
      sel_a_d   = !advance ? 2'b00 : (ex_a && !ex_mr_q) ? 2'b10 : mem_a ? 2'b01 : 2'b00;
      sel_b_d   = !advance ? 2'b00 : (ex_b && !ex_mr_q) ? 2'b10 : mem_b ? 2'b01 : 2'b00;
      cnt_d     = mdu_go ? CW'(MDU_LAT) : (cnt_q != '0) ? cnt_q - CW'(1) : '0;
   end
   // Shadow pipe advance, registered forwarding selects and MDU countdown
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_q  <= 1'b0;
         ex_rw_q     <= 1'b0;
         ex_mr_q     <= 1'b0;
         ex_dst_q    <= '0;
         mem_valid_q <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_dst_q   <= '0;
         sel_a_q     <= 2'b00;
         sel_b_q     <= 2'b00;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
      end else begin
         mem_valid_q <= ex_valid_q;
         mem_rw_q    <= ex_rw_q;
         mem_dst_q   <= ex_dst_q;
         ex_valid_q  <= advance;
         ex_rw_q     <= advance && id_regwrite;
         ex_mr_q     <= advance && id_memread;
         ex_dst_q    <= advance ? id_dst : '0;
         sel_a_q     <= sel_a_d;
         sel_b_q     <= sel_b_d;
         cnt_q       <= cnt_d;
         busy_q      <= cnt_d != '0;
      end
   end
   assign fwd_a_sel = sel_a_q;
   assign fwd_b_sel = sel_b_q;
   assign mdu_busy  = busy_q;
`ifdef FWD_STATS_EN
   logic [STAT_W-1:0] stall_cnt_q, alu_cnt_q, mem_cnt_q;
   // Wrapping event counters: stall cycles and per-operand registered forward selects
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         alu_cnt_q   <= '0;
         mem_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_q + STAT_W'(stall);
         alu_cnt_q   <= alu_cnt_q + STAT_W'(sel_a_q == 2'b10) + STAT_W'(sel_b_q == 2'b10);
         mem_cnt_q   <= mem_cnt_q + STAT_W'(sel_a_q == 2'b01) + STAT_W'(sel_b_q == 2'b01);
      end
   end
   assign stat_stall_cnt   = stall_cnt_q;
   assign stat_fwd_alu_cnt = alu_cnt_q;
   assign stat_fwd_mem_cnt = mem_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed hazard/forwarding sequences against hand-derived expectations (MDU_LAT=4).
module tb_fwd_hazard_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_regwrite = 1'b0;
   logic       id_memread = 1'b0, id_mdu_start = 1'b0, id_use_hilo = 1'b0, flush = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
   logic       stall, mdu_busy;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   int         errors = 0, checks = 0;
`ifdef FWD_STATS_EN
   logic [31:0] stat_stall_cnt, stat_fwd_alu_cnt, stat_fwd_mem_cnt;
`endif
   fwd_hazard_ctrl #(.REG_AW(5), .MDU_LAT(4), .STAT_W(32)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_dst(id_dst), .id_mdu_start(id_mdu_start),
      .id_use_hilo(id_use_hilo), .flush(flush), .stall(stall), .fwd_a_sel(fwd_a_sel),
`ifdef FWD_STATS_EN
      .stat_stall_cnt(stat_stall_cnt), .stat_fwd_alu_cnt(stat_fwd_alu_cnt),
      .stat_fwd_mem_cnt(stat_fwd_mem_cnt),
`endif
      .fwd_b_sel(fwd_b_sel), .mdu_busy(mdu_busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic rw, input logic mr, input logic [4:0] dst,
                     input logic ms, input logic uh);
      id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_regwrite = rw; id_memread = mr; id_dst = dst; id_mdu_start = ms; id_use_hilo = uh;
      #1;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      repeat (2) tick();
      chk("rst_sel_a", 32'(fwd_a_sel), 0);
      chk("rst_sel_b", 32'(fwd_b_sel), 0);
      chk("rst_busy", 32'(mdu_busy), 0);
      chk("rst_stall", 32'(stall), 0);
      reset = 1'b0;
      tick();
      // add $3,$1,$2 ; add $4,$3,$5 -> ALU forward on A
      id(1, 1, 2, 1, 1, 1, 0, 3, 0, 0);
      tick();
      id(1, 3, 5, 1, 1, 1, 0, 4, 0, 0);
      chk("alu_fwd_stall", 32'(stall), 0);
      tick();
      chk("alu_fwd_a", 32'(fwd_a_sel), 2);
      chk("alu_fwd_b", 32'(fwd_b_sel), 0);
      // add $3 ; nop ; sub $6,$5,$3 -> MEM forward on B
      id(1, 1, 2, 1, 1, 1, 0, 3, 0, 0);
      tick();
      id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      id(1, 5, 3, 1, 1, 1, 0, 6, 0, 0);
      chk("mem_fwd_stall", 32'(stall), 0);
      tick();
      chk("mem_fwd_a", 32'(fwd_a_sel), 0);
      chk("mem_fwd_b", 32'(fwd_b_sel), 1);
      // lw $3 ; add $4,$3,$3 -> one stall, bubble, then 01/01
      id(1, 1, 0, 1, 0, 1, 1, 3, 0, 0);
      tick();
      id(1, 3, 3, 1, 1, 1, 0, 4, 0, 0);
      chk("lu_stall", 32'(stall), 1);
      tick();
      chk("lu_bubble_a", 32'(fwd_a_sel), 0);
      chk("lu_bubble_b", 32'(fwd_b_sel), 0);
      chk("lu_stall_end", 32'(stall), 0);
      tick();
      chk("lu_fwd_a", 32'(fwd_a_sel), 1);
      chk("lu_fwd_b", 32'(fwd_b_sel), 1);
      // write to $0 then read $0 -> no forward
      id(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      tick();
      id(1, 0, 0, 1, 1, 1, 0, 4, 0, 0);
      tick();
      chk("zero_a", 32'(fwd_a_sel), 0);
      chk("zero_b", 32'(fwd_b_sel), 0);
      // two producers of $3 in MEM and EX -> newest (EX) wins
      id(1, 1, 0, 1, 0, 1, 0, 3, 0, 0);
      tick();
      id(1, 2, 0, 1, 0, 1, 0, 3, 0, 0);
      tick();
      id(1, 3, 3, 1, 1, 1, 0, 7, 0, 0);
      tick();
      chk("newest_a", 32'(fwd_a_sel), 2);
      chk("newest_b", 32'(fwd_b_sel), 2);
      // mult then mflo -> 4 stall cycles, then issue
      id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);
      chk("mult_stall", 32'(stall), 0);
      tick();
      chk("mult_busy", 32'(mdu_busy), 1);
      id(1, 0, 0, 0, 0, 1, 0, 8, 0, 1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("mflo_stall%0d", i), 32'(stall), 1);
         tick();
      end
      chk("mflo_issue", 32'(stall), 0);
      chk("mdu_done", 32'(mdu_busy), 0);
      tick();
      // flushed mult never starts the MDU
      id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("flush_busy", 32'(mdu_busy), 0);
      tick();
      chk("flush_busy2", 32'(mdu_busy), 0);
      // reset mid-run with MDU busy, ALU forward live and a stall pending
      id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);
      tick();
      id(1, 1, 2, 1, 1, 1, 0, 3, 0, 0);
      tick();
      id(1, 3, 0, 1, 0, 1, 0, 4, 0, 0);
      tick();
      chk("pre_rst_a", 32'(fwd_a_sel), 2);
      id(1, 0, 0, 0, 0, 1, 0, 9, 0, 1);
      chk("pre_rst_stall", 32'(stall), 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_a", 32'(fwd_a_sel), 0);
      chk("mid_rst_b", 32'(fwd_b_sel), 0);
      chk("mid_rst_busy", 32'(mdu_busy), 0);
      chk("mid_rst_stall", 32'(stall), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
